// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 opcodes and the control FSM state encoding.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the issue stage (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_val;

  modport master (
    output start, flush, op, rs1_val, rs2_val, rd,
    input  busy, done, wb_we, wb_rd, wb_val
  );

  modport slave (
    input  start, flush, op, rs1_val, rs2_val, rd,
    output busy, done, wb_we, wb_rd, wb_val
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide
// on unsigned magnitudes sharing one 2*XLEN accumulator, sign fixed up at the end.
module muldiv_unit #(
  parameter int XLEN = muldiv_unit_pkg::XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   wb_val_q, wb_val_d;
  logic [4:0]        wb_rd_q, wb_rd_d;

  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_val;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, rem_fix, fix_res;

  // Operand decode for the request currently on the bus.
  always_comb begin
    a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    sign_a   = a_signed & bus.rs1_val[XLEN-1];
    sign_b   = b_signed & bus.rs2_val[XLEN-1];
    mag_a    = sign_a ? -bus.rs1_val : bus.rs1_val;
    mag_b    = sign_b ? -bus.rs2_val : bus.rs2_val;
    div_zero = bus.op[2] && (bus.rs2_val == '0);
    div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
    if (div_zero) begin
      fast_val = bus.op[1] ? bus.rs1_val : '1;
    end else begin
      fast_val = bus.op[1] ? '0 : MIN_NEG;
    end
  end

  // Low half holds multiplier / dividend-then-quotient; high half holds product / remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    prod      = neg_q ? -acc_q : acc_q;
    rem_fix   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_fix : prod[XLEN-1:0];
    end else begin
      fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    wb_val_d = wb_val_q;
    wb_rd_d  = wb_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d   = bus.op;
          rd_d   = bus.rd;
          cnt_d  = '0;
          acc_d  = {{XLEN{1'b0}}, mag_a};
          opnd_d = mag_b;
          neg_d  = (bus.op == OP_REM) ? sign_a : (sign_a ^ sign_b);
          if (div_zero || div_ovf) begin
            wb_val_d = fast_val;
            wb_rd_d  = bus.rd;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          wb_val_d = fix_res;
          wb_rd_d  = rd_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      wb_val_q <= '0;
      wb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      wb_val_q <= wb_val_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // A flush landing on the DONE cycle cancels the write-back.
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE) && !bus.flush;
  assign bus.wb_we  = bus.done && (wb_rd_q != 5'd0);
  assign bus.wb_rd  = wb_rd_q;
  assign bus.wb_val = wb_val_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency,
// fast paths, flush, ignored start, rd==0 and async reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cycle;
  logic saw_done;

  muldiv_unit_if bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd      = rd;
    bus.start   = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_val, input int exp_lat, input logic exp_we);
    int lat;
    apply_stimulus(op, a, b, rd);
    tick();
    bus.start = 1'b0;
    lat = 1;
    check_output({tag, "_busy1"}, 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 60) begin
      tick();
      lat++;
    end
    check_output({tag, "_latency"}, lat, exp_lat);
    check_output({tag, "_val"}, bus.wb_val, exp_val);
    check_output({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
    check_output({tag, "_we"}, 32'(bus.wb_we), 32'(exp_we));
    tick();
    check_output({tag, "_done_after"}, 32'(bus.done), 32'd0);
    check_output({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cycle       = 0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 3'd0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd      = '0;
    rst_n       = 1'b0;
    repeat (2) tick();
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_we", 32'(bus.wb_we), 32'd0);
    check_output("reset_rd", 32'(bus.wb_rd), 32'd0);
    check_output("reset_val", bus.wb_val, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul_neg",  OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 1'b1);
    run_op("mulh_min", OP_MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, 1'b1);
    run_op("mulhu",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34, 1'b1);
    run_op("mulhsu",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34, 1'b1);
    run_op("div_neg",  OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34, 1'b1);
    run_op("rem_neg",  OP_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34, 1'b1);
    run_op("divu_big", OP_DIVU,   32'hFFFFFFF0, 32'd3,        5'd11, 32'h55555550, 34, 1'b1);
    run_op("remu",     OP_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        34, 1'b1);
    run_op("divu_z",   OP_DIVU,   32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1,  1'b1);
    run_op("rem_z",    OP_REM,    32'd5,        32'd0,        5'd14, 32'd5,        1,  1'b1);
    run_op("div_ovf",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  1'b1);
    run_op("rem_ovf",  OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1,  1'b1);
    run_op("mul_rd0",  OP_MUL,    32'd3,        32'd4,        5'd0,  32'd12,       34, 1'b0);

    // Flush in cycle 10 of a DIV, then a MUL issued in cycle 11 lands in cycle 45.
    cycle = 0;
    saw_done = 1'b0;
    apply_stimulus(OP_DIV, 32'd1000, 32'd10, 5'd4);
    tick();
    bus.start = 1'b0;
    while (cycle < 10) begin
      saw_done |= bus.done;
      tick();
    end
    saw_done |= bus.done;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_output("flush_no_done", 32'(saw_done | bus.done), 32'd0);
    check_output("flush_busy11", 32'(bus.busy), 32'd0);
    check_output("flush_cycle", cycle, 32'd11);
    run_op("mul_after_flush", OP_MUL, 32'd6, 32'd7, 5'd3, 32'd42, 34, 1'b1);

    // A start pulse in cycle 5 must not disturb the running DIVU.
    cycle = 0;
    apply_stimulus(OP_DIVU, 32'd100, 32'd7, 5'd9);
    tick();
    bus.start = 1'b0;
    while (cycle < 5) tick();
    apply_stimulus(OP_MUL, 32'd3, 32'd4, 5'd2);
    tick();
    bus.start = 1'b0;
    while (!bus.done && cycle < 60) tick();
    check_output("ignore_start_cycle", cycle, 32'd34);
    check_output("ignore_start_val", bus.wb_val, 32'd14);
    check_output("ignore_start_rd", 32'(bus.wb_rd), 32'd9);
    tick();
    check_output("ignore_start_idle", 32'(bus.busy), 32'd0);

    // Async reset in cycle 20 of a MUL clears outputs without waiting for a clock edge.
    cycle = 0;
    apply_stimulus(OP_MUL, 32'd9, 32'd9, 5'd1);
    tick();
    bus.start = 1'b0;
    while (cycle < 20) tick();
    check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("areset_busy", 32'(bus.busy), 32'd0);
    check_output("areset_done", 32'(bus.done), 32'd0);
    check_output("areset_we", 32'(bus.wb_we), 32'd0);
    check_output("areset_val", bus.wb_val, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_reset_busy", 32'(bus.busy), 32'd0);
    run_op("mul_after_reset", OP_MUL, 32'd9, 32'd9, 5'd1, 32'd81, 34, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register bank. It consumes the `rs1_val`/`rs2_val` operands read for an M-extension instruction, computes the result over multiple cycles, and presents a one-cycle write-back request (`wb_rd`, `wb_val`, `wb_we`) that feeds the register bank write port. The pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported. The iteration count equals `XLEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val`  in  XLEN  dividend / multiplicand.
- `rs2_val`  in  XLEN  divisor / multiplier.
- `rd`  in  5  destination register index.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `wb_*` are valid in that cycle.
- `wb_we`  out  1  equals `done && (wb_rd != 0)`.
- `wb_rd`  out  5  latched `rd`.
- `wb_val`  out  XLEN  result.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state IDLE; `busy`, `done`, `wb_we` = 0; `wb_rd` = 0; `wb_val` = 0; all internal registers 0.
- **IDLE & start & !flush:**
  - Latch `op` and `rd`.
  - Latch operand magnitudes and result-sign flags:
    - MULH/DIV/REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU/DIVU/REMU/MUL: unsigned.
  - Next state is CALC, except on the fast path, where the next state is DONE with `wb_val` already set.
- **Fast path (any divide op with `rs2_val` == 0):** quotient = 0xFFFFFFFF; remainder = `rs1_val`.
- **Fast path (DIV/REM with 0x80000000 / 0xFFFFFFFF):** quotient = 0x80000000; remainder = 0.
- **CALC, multiply:** shift-add, one multiplier bit per cycle into a 64-bit accumulator, for 32 cycles.
- **CALC, divide:** restoring division, one quotient bit per cycle, 32 cycles, with a 33-bit partial remainder.
  - 5-bit counter counts 0..31; at 31 the next state is FIX.
- **FIX:** conditional two's-complement negation, then result select.
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - `wb_val` is registered; next state DONE.
- **DONE:** `done` = 1 for exactly one cycle; next state IDLE. `start` is ignored in DONE because `busy` is high.
- **start while busy:** ignored; no queueing.
- **flush:** in any non-IDLE state, next state IDLE and no `done` is produced. `flush` during DONE also suppresses `done`. `flush` and `start` together in IDLE: flush wins, request dropped.
- **rd == 0:** full computation runs and `done` pulses, but `wb_we` = 0.
- **Async reset mid-operation:** immediate return to IDLE with all reset values.

## Timing
- `start` sampled high in cycle 0.
- **Normal ops:**
  - `busy` is high in cycles 1–34.
  - CALC occupies cycles 1–32; FIX is cycle 33.
  - DONE is cycle 34: `done`, `wb_*` valid.
  - Next `start` is accepted in cycle 35.
- **Fast path:** DONE in cycle 1; `busy` high in cycle 1 only.
- **Flush:** `flush` high in cycle k leaves IDLE, with `busy` = 0, in cycle k+1. A new `start` is accepted in cycle k+1.
- **Output hold:** `wb_val`/`wb_rd` hold their value after DONE until the next FIX or fast path. Consumers use them only when `done` is high.

## Structure
- **Shared package:**
  - funct3 op localparams (MUL..REMU).
  - State enum.
  - `XLEN` constant shared with the register bank.
- **Module organisation:** single module. No sub-module is needed; the sign handling and the iteration datapath share the accumulator register.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5: `wb_val`=0xFFFFFFEB, `wb_rd`=5, `wb_we`=1, `done` in cycle 34 only.
- Multiply-high cases:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- Fast-path cases, each with `done` in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- `flush` in cycle 10 of a DIV: no `done`, `busy`=0 in cycle 11, and a MUL started in cycle 11 completes in cycle 45. A `start` pulse in cycle 5 of an op is ignored.
- Zero destination and reset:
  - MUL 3×4 with rd=0: `done`=1, `wb_we`=0, `wb_val`=12.
  - `rst_n` low in cycle 20 of CALC: `busy`/`done`/`wb_we`/`wb_val` = 0 immediately, state IDLE.
